// File: rtl/bus_xcvr_pkg.sv
// Shared types for the bus_xcvr_reg registered bidirectional transceiver.
package bus_xcvr_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    DRV_AB = 2'd1,
    DRV_BA = 2'd2,
    TURN   = 2'd3
  } xcvr_state_t;

  localparam int TURN_CNT_W = 4;

endpackage

// File: rtl/bus_xcvr_ctrl.sv
// Direction FSM with turnaround guard; drive flags are registered and
// derived from the next state so they never glitch.
//
//   state  | meaning
//   OFF    | nothing driven (oe_n high or after reset)
//   DRV_AB | B side driven from A path
//   DRV_BA | A side driven from B path
//   TURN   | dead cycles between directions, busy high
module bus_xcvr_ctrl
  import bus_xcvr_pkg::*;
#(
  parameter int TURN_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic oe_n,
  input  logic dir,
  output logic a_drive,
  output logic b_drive,
  output logic busy
);

  localparam logic [TURN_CNT_W-1:0] TURN_LOAD =
    (TURN_CYCLES > 0) ? TURN_CNT_W'(TURN_CYCLES - 1) : '0;
  localparam bit NO_TURN = (TURN_CYCLES == 0);

  xcvr_state_t             state_q, state_d;
  logic [TURN_CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        if (!oe_n) state_d = dir ? DRV_AB : DRV_BA;
      end
      DRV_AB: begin
        if (oe_n) begin
          state_d = OFF;
        end else if (!dir) begin
          if (NO_TURN) begin
            state_d = DRV_BA;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      DRV_BA: begin
        if (oe_n) begin
          state_d = OFF;
        end else if (dir) begin
          if (NO_TURN) begin
            state_d = DRV_AB;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN: begin
        // dir is only looked at when the count expires, so late toggles just pick the winner
        if (oe_n) begin
          state_d = OFF;
        end else if (cnt_q == '0) begin
          state_d = dir ? DRV_AB : DRV_BA;
        end else begin
          cnt_d = cnt_q - TURN_CNT_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      a_drive <= 1'b0;
      b_drive <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_drive <= (state_d == DRV_AB);
      a_drive <= (state_d == DRV_BA);
      busy    <= (state_d == TURN);
    end
  end

endmodule

// File: rtl/bus_xcvr_reg.sv
// Registered bidirectional bus transceiver (74xx646/652 style) with turnaround guard.
// Optional simulation checks enabled by defining BUS_XCVR_ASSERT_EN.
module bus_xcvr_reg
  import bus_xcvr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe_n,
  input  logic             dir,
  input  logic             sab,
  input  logic             sba,
  input  logic             cab,
  input  logic             cba,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_out,
  output logic             a_drive,
  output logic [WIDTH-1:0] b_out,
  output logic             b_drive,
  output logic             busy
);

  logic [WIDTH-1:0] reg_a, reg_b;

  bus_xcvr_ctrl #(
    .TURN_CYCLES (TURN_CYCLES)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .oe_n    (oe_n),
    .dir     (dir),
    .a_drive (a_drive),
    .b_drive (b_drive),
    .busy    (busy)
  );

  // Storage registers capture regardless of drive state or oe_n
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      if (cab) reg_a <= a_in;
      if (cba) reg_b <= b_in;
    end
  end

  assign b_out = b_drive ? (sab ? reg_a : a_in) : '0;
  assign a_out = a_drive ? (sba ? reg_b : b_in) : '0;

`ifdef BUS_XCVR_ASSERT_EN
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "bus_xcvr_reg: WIDTH %0d outside 1..64", WIDTH);
  end
  if (TURN_CYCLES < 0 || TURN_CYCLES > 15) begin : g_bad_turn
    $fatal(1, "bus_xcvr_reg: TURN_CYCLES %0d outside 0..15", TURN_CYCLES);
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (a_drive && b_drive)
        $fatal(1, "bus_xcvr_reg: a_drive and b_drive both active");
      if ($isunknown({oe_n, dir}))
        $fatal(1, "bus_xcvr_reg: oe_n/dir unknown at clock edge");
    end
  end
`endif

endmodule

// File: tb/tb_bus_xcvr_reg.sv
// Scoreboard bench for bus_xcvr_reg: a driver queues expected outputs per cycle,
// a negedge monitor pops and compares against the selected instance.
module tb_bus_xcvr_reg;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic        oe_n = 1'b1, dir = 1'b0, sab = 1'b0, sba = 1'b0, cab = 1'b0, cba = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;

  logic [7:0]  a_out0, b_out0;
  logic        a_drive0, b_drive0, busy0;
  logic [15:0] a_out1, b_out1;
  logic        a_drive1, b_drive1, busy1;

  always #5 clk = ~clk;

  bus_xcvr_reg #(.WIDTH(8), .TURN_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst0), .oe_n(oe_n), .dir(dir), .sab(sab), .sba(sba),
    .cab(cab), .cba(cba), .a_in(a_in[7:0]), .b_in(b_in[7:0]),
    .a_out(a_out0), .a_drive(a_drive0), .b_out(b_out0), .b_drive(b_drive0), .busy(busy0)
  );

  bus_xcvr_reg #(.WIDTH(16), .TURN_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst1), .oe_n(oe_n), .dir(dir), .sab(sab), .sba(sba),
    .cab(cab), .cba(cba), .a_in(a_in), .b_in(b_in),
    .a_out(a_out1), .a_drive(a_drive1), .b_out(b_out1), .b_drive(b_drive1), .busy(busy1)
  );

  typedef struct {
    string       name;
    bit          which;
    logic        ad, bd, bsy;
    logic [15:0] ao, bo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   driver_done = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input bit which, input logic ad, input logic bd,
                            input logic bsy, input logic [15:0] ao, input logic [15:0] bo);
    exp_t e;
    e.name = name; e.which = which; e.ad = ad; e.bd = bd; e.bsy = bsy; e.ao = ao; e.bo = bo;
    exp_q.push_back(e);
  endtask

  // Monitor: every negedge, compare the outputs against the oldest queued expectation
  initial begin
    exp_t        e;
    logic        ad, bd, bsy;
    logic [15:0] ao, bo;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.which) begin
          ad = a_drive1; bd = b_drive1; bsy = busy1; ao = a_out1; bo = b_out1;
        end else begin
          ad = a_drive0; bd = b_drive0; bsy = busy0; ao = {8'h00, a_out0}; bo = {8'h00, b_out0};
        end
        n_checks++;
        if (ad === e.ad && bd === e.bd && bsy === e.bsy && ao === e.ao && bo === e.bo && !(ad && bd))
          n_pass++;
        else
          $display("FAIL %s: got ad=%b bd=%b busy=%b a_out=%h b_out=%h, want ad=%b bd=%b busy=%b a_out=%h b_out=%h",
                   e.name, ad, bd, bsy, ao, bo, e.ad, e.bd, e.bsy, e.ao, e.bo);
      end
    end
  end

  initial begin
    // ---- instance 0: WIDTH=8, TURN_CYCLES=3 ----
    tick(); oe_n = 0; dir = 1; a_in = 16'h005A;
    expect_out("rst_hold", 0, 0, 0, 0, 16'h0, 16'h0);
    tick(); rst0 = 0;
    expect_out("rst_release_off", 0, 0, 0, 0, 16'h0, 16'h0);
    tick();
    expect_out("enable_ab", 0, 0, 1, 0, 16'h0, 16'h005A);
    tick(); dir = 0;
    expect_out("pre_turn", 0, 0, 1, 0, 16'h0, 16'h005A);
    tick(); expect_out("turn_1", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); expect_out("turn_2", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); expect_out("turn_3", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); b_in = 16'h003C;
    expect_out("turn_done_ba", 0, 1, 0, 0, 16'h003C, 16'h0);
    tick(); dir = 1; a_in = 16'h00C3; cab = 1;
    expect_out("ba_hold", 0, 1, 0, 0, 16'h003C, 16'h0);
    tick(); cab = 0; a_in = 16'h0000; sab = 1;
    expect_out("turn2_1", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); expect_out("turn2_2", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); expect_out("turn2_3", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); expect_out("stored_a", 0, 0, 1, 0, 16'h0, 16'h00C3);
    tick(); cab = 1; a_in = 16'h0011;
    expect_out("capture_old", 0, 0, 1, 0, 16'h0, 16'h00C3);
    tick(); cab = 0; a_in = 16'h0000;
    expect_out("capture_new", 0, 0, 1, 0, 16'h0, 16'h0011);
    tick(); dir = 0;
    expect_out("abort_pre", 0, 0, 1, 0, 16'h0, 16'h0011);
    tick(); expect_out("abort_turn_1", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); oe_n = 1;
    expect_out("abort_turn_2", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); oe_n = 0; dir = 0;
    expect_out("abort_off", 0, 0, 0, 0, 16'h0, 16'h0);
    tick(); cba = 1; b_in = 16'h00FF;
    expect_out("reenable_ba", 0, 1, 0, 0, 16'h00FF, 16'h0);
    tick(); cba = 0; sba = 1; b_in = 16'h0000; dir = 1;
    expect_out("stored_b", 0, 1, 0, 0, 16'h00FF, 16'h0);
    tick(); expect_out("rst_turn_1", 0, 0, 0, 1, 16'h0, 16'h0);
    tick(); rst0 = 1;
    expect_out("async_rst_mid_turn", 0, 0, 0, 0, 16'h0, 16'h0);
    tick(); rst0 = 0; dir = 0; b_in = 16'h00AA;
    expect_out("post_rst_off", 0, 0, 0, 0, 16'h0, 16'h0);
    tick(); expect_out("reg_b_cleared", 0, 1, 0, 0, 16'h0, 16'h0);

    // ---- instance 1: WIDTH=16, TURN_CYCLES=0 ----
    tick(); rst0 = 1; rst1 = 0; oe_n = 0; dir = 1; sab = 0; sba = 0;
    a_in = 16'h1234; b_in = 16'hBEEF;
    expect_out("w16_off", 1, 0, 0, 0, 16'h0, 16'h0);
    tick(); dir = 0;
    expect_out("w16_ab", 1, 0, 1, 0, 16'h0, 16'h1234);
    tick(); dir = 1;
    expect_out("w16_flip_ba", 1, 1, 0, 0, 16'hBEEF, 16'h0);
    tick(); dir = 0;
    expect_out("w16_flip_ab", 1, 0, 1, 0, 16'h0, 16'h1234);
    tick(); oe_n = 1;
    expect_out("w16_flip_ba2", 1, 1, 0, 0, 16'hBEEF, 16'h0);
    tick(); expect_out("w16_off_again", 1, 0, 0, 0, 16'h0, 16'h0);
    driver_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!(driver_done && exp_q.size() == 0) && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_checks++;
      $display("FAIL timeout: got %0d pending expectations, want 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
